// File: rtl/dense_update_w_block_pkg.sv
// Shared training constants, FSM state type and the saturation helper
// for the dense-layer weight-update stage.
package dense_update_w_block_pkg;

  localparam int DEF_HID_DIM  = 24;
  localparam int DEF_CHAR_NUM = 176;
  localparam int DEF_DATA_N   = 16;
  localparam int DEF_N_LEN    = 16;
  localparam int DEF_N_LEN_W  = 8;
  localparam int DEF_FRAC_W   = 6;
  localparam int DEF_LR_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp an N_LEN+1 bit difference back into the signed N_LEN weight range.
  function automatic logic [DEF_N_LEN-1:0] sat_w(input logic [DEF_N_LEN:0] v);
    logic [DEF_N_LEN-1:0] r;
    if (v[DEF_N_LEN] != v[DEF_N_LEN-1]) begin
      r = v[DEF_N_LEN] ? {1'b1, {(DEF_N_LEN-1){1'b0}}} : {1'b0, {(DEF_N_LEN-1){1'b1}}};
    end else begin
      r = v[DEF_N_LEN-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dense_update_w_block_lane.sv
// One SGD lane: registered x*d product, then registered floor-shift,
// subtract from the old weight and saturate.
module dense_update_lane
  import dense_update_w_block_pkg::*;
#(
  parameter int N_LEN   = DEF_N_LEN,
  parameter int N_LEN_W = DEF_N_LEN_W,
  parameter int SHIFT   = DEF_FRAC_W + DEF_LR_SHIFT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LEN-1:0]   x,
  input  logic [N_LEN_W-1:0] d,
  input  logic [N_LEN-1:0]   w,
  output logic [N_LEN-1:0]   w_new
);

  localparam int P_W = N_LEN + N_LEN_W;

  logic signed [P_W-1:0]   p;
  logic        [N_LEN-1:0] w_q;
  logic signed [P_W-1:0]   delta;
  logic signed [N_LEN:0]   diff;

  // Arithmetic shift of a signed product is a floor division by 2^SHIFT.
  assign delta = p >>> SHIFT;
  assign diff  = $signed({w_q[N_LEN-1], w_q}) - $signed(delta[N_LEN:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p     <= '0;
      w_q   <= '0;
      w_new <= '0;
    end else begin
      p     <= P_W'($signed(x)) * P_W'($signed(d));
      w_q   <= w;
      w_new <= sat_w(diff);
    end
  end

endmodule

// File: rtl/dense_update_w_block.sv
// In-place SGD weight update: streams every weight RAM word through a
// 3-stage read-modify-write pipeline and flags completion with valid.
module dense_update_w_block
  import dense_update_w_block_pkg::*;
#(
  parameter int HID_DIM  = DEF_HID_DIM,
  parameter int CHAR_NUM = DEF_CHAR_NUM,
  parameter int DATA_N   = DEF_DATA_N,
  parameter int N_LEN    = DEF_N_LEN,
  parameter int N_LEN_W  = DEF_N_LEN_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int LR_SHIFT = DEF_LR_SHIFT,
  localparam int ADDR_W  = $clog2(HID_DIM * CHAR_NUM / DATA_N)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [HID_DIM*N_LEN-1:0]    x,
  input  logic [CHAR_NUM*N_LEN_W-1:0] d,
  output logic [ADDR_W-1:0]           raddr,
  input  logic [DATA_N*N_LEN-1:0]     rdata,
  output logic [ADDR_W-1:0]           waddr,
  output logic [DATA_N*N_LEN-1:0]     wdata,
  output logic                        we,
  output logic                        valid
);

  localparam int CHUNKS = CHAR_NUM / DATA_N;
  localparam int NWORDS = HID_DIM * CHUNKS;
  localparam int H_W    = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int K_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NWORDS - 1);
  localparam logic [K_W-1:0]    LAST_K = K_W'(CHUNKS - 1);

  state_t state, next_state;

  logic [H_W-1:0]    h_cnt, h1;
  logic [K_W-1:0]    k_cnt, k1;
  logic [ADDR_W-1:0] a1, a2;
  logic              v0, v1, v2, v3;

  logic [N_LEN-1:0]          x_row   [HID_DIM];
  logic [DATA_N*N_LEN_W-1:0] d_chunk [CHUNKS];
  logic [DATA_N*N_LEN_W-1:0] d_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!run) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = READ;
        READ:    next_state = (raddr == LAST_A) ? DRAIN : READ;
        DRAIN:   next_state = (v3 && waddr == LAST_A) ? DONE : DRAIN;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign v0 = (state == READ) && run;
  assign we = v3 && run;

  // Read address walks row-major; h/k track the row and column chunk of raddr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr <= '0;
      h_cnt <= '0;
      k_cnt <= '0;
    end else if (v0 && raddr != LAST_A) begin
      raddr <= raddr + ADDR_W'(1);
      if (k_cnt == LAST_K) begin
        k_cnt <= '0;
        h_cnt <= h_cnt + H_W'(1);
      end else begin
        k_cnt <= k_cnt + K_W'(1);
      end
    end else begin
      raddr <= '0;
      h_cnt <= '0;
      k_cnt <= '0;
    end
  end

  // Valid/address delay line; dropping run flushes in-flight words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      h1    <= '0;
      k1    <= '0;
      a1    <= '0;
      a2    <= '0;
      waddr <= '0;
      valid <= 1'b0;
    end else begin
      v1    <= v0;
      v2    <= v1 && run;
      v3    <= v2 && run;
      h1    <= h_cnt;
      k1    <= k_cnt;
      a1    <= raddr;
      a2    <= a1;
      waddr <= a2;
      valid <= (next_state == DONE);
    end
  end

  for (genvar i = 0; i < HID_DIM; i++) begin : g_xrow
    assign x_row[i] = x[i*N_LEN +: N_LEN];
  end

  for (genvar i = 0; i < CHUNKS; i++) begin : g_dchunk
    assign d_chunk[i] = d[i*DATA_N*N_LEN_W +: DATA_N*N_LEN_W];
  end

  assign d_sel = d_chunk[k1];

  for (genvar l = 0; l < DATA_N; l++) begin : g_lane
    dense_update_lane #(
      .N_LEN   (N_LEN),
      .N_LEN_W (N_LEN_W),
      .SHIFT   (FRAC_W + LR_SHIFT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .x     (x_row[h1]),
      .d     (d_sel[l*N_LEN_W +: N_LEN_W]),
      .w     (rdata[l*N_LEN +: N_LEN]),
      .w_new (wdata[l*N_LEN +: N_LEN])
    );
  end

endmodule

// File: tb/tb_dense_update_w_block.sv
// Directed bench for dense_update_w_block: bench-side RAM, floor-division
// SGD reference model and a per-cycle compare process.
module tb_dense_update_w_block;
  import dense_update_w_block_pkg::*;

  localparam int HD = DEF_HID_DIM;
  localparam int CN = DEF_CHAR_NUM;
  localparam int DN = DEF_DATA_N;
  localparam int CH = CN / DN;
  localparam int NW = HD * CH;
  localparam int AW = $clog2(NW);
  localparam int WW = DN * 16;
  localparam int SCALE = 1 << (DEF_FRAC_W + DEF_LR_SHIFT);

  logic          clk = 1'b0;
  logic          rst, run;
  logic [HD*16-1:0] x_bus;
  logic [CN*8-1:0]  d_bus;
  logic [AW-1:0] raddr, waddr;
  logic [WW-1:0] rdata, wdata;
  logic          we, valid;

  always #5 clk = ~clk;

  dense_update_w_block dut (
    .clk(clk), .rst(rst), .run(run), .x(x_bus), .d(d_bus),
    .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata),
    .we(we), .valid(valid)
  );

  int            xv [HD];
  int            dv [CN];
  logic [WW-1:0] mem [NW];
  logic [WW-1:0] init_mem [NW];
  logic [WW-1:0] stage_mem [NW];
  logic          load_req = 1'b0;

  int   checks = 0, failures = 0;
  int   cyc = 0, chk_last = 0, we_cnt = 0;
  logic chk_on = 1'b0;

  // Weight RAM with one-cycle read latency; preload only while the DUT is idle.
  always @(posedge clk) begin
    rdata <= mem[raddr];
    if (load_req) begin
      for (int i = 0; i < NW; i++) mem[i] <= stage_mem[i];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  function automatic void chk(string nm, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // w - floor(x*d / 2^(FRAC_W+LR_SHIFT)), clamped to the int16 range.
  function automatic int upd(int w, int xx, int dd);
    int p, delta, nw;
    p = xx * dd;
    if (p >= 0) delta = p / SCALE;
    else        delta = -((-p + SCALE - 1) / SCALE);
    nw = w - delta;
    if (nw > 32767)  nw = 32767;
    if (nw < -32768) nw = -32768;
    return nw;
  endfunction

  function automatic int lane_of(logic [WW-1:0] wd, int l);
    logic signed [15:0] s;
    s = wd[l*16 +: 16];
    return int'(s);
  endfunction

  function automatic logic [WW-1:0] model_word(int a);
    logic [WW-1:0] r;
    int h, k;
    h = a / CH;
    k = a % CH;
    for (int l = 0; l < DN; l++)
      r[l*16 +: 16] = 16'(upd(lane_of(init_mem[a], l), xv[h], dv[k*DN + l]));
    return r;
  endfunction

  // Per-cycle check of the read/write stream against the pass timeline.
  always @(negedge clk) begin
    if (chk_on) begin
      if (cyc < NW) chk($sformatf("raddr@%0d", cyc), WW'(raddr), WW'(cyc));
      chk($sformatf("we@%0d", cyc), WW'(we), WW'(cyc >= 3 && cyc <= NW + 2));
      if (cyc >= 3 && cyc <= NW + 2) begin
        chk($sformatf("waddr@%0d", cyc), WW'(waddr), WW'(cyc - 3));
        chk($sformatf("wdata@%0d", cyc), wdata, model_word(cyc - 3));
      end
      chk($sformatf("valid@%0d", cyc), WW'(valid), WW'(cyc >= NW + 3));
      if (we) we_cnt++;
      if (cyc == chk_last) chk_on = 1'b0;
      cyc++;
    end
  end

  task automatic load_ram();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic set_lane(int a, int l, int v);
    logic [WW-1:0] t;
    t = stage_mem[a];
    t[l*16 +: 16] = 16'(v);
    stage_mem[a] = t;
  endtask

  task automatic randomize_all();
    for (int h = 0; h < HD; h++) xv[h] = int'($signed(16'($urandom())));
    for (int c = 0; c < CN; c++) dv[c] = int'($signed(8'($urandom())));
    for (int a = 0; a < NW; a++)
      stage_mem[a] = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic start_pass(int last);
    for (int h = 0; h < HD; h++) x_bus[h*16 +: 16] = 16'(xv[h]);
    for (int c = 0; c < CN; c++) d_bus[c*8 +: 8] = 8'(dv[c]);
    for (int a = 0; a < NW; a++) init_mem[a] = mem[a];
    we_cnt = 0;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    chk_last = last;
    chk_on = 1'b1;
  endtask

  task automatic wait_chk();
    for (int i = 0; i < NW + 100; i++) begin
      @(posedge clk);
      if (!chk_on) break;
    end
    if (chk_on) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=still_checking required=done");
      chk_on = 1'b0;
    end
  endtask

  task automatic check_ram(int limit);
    for (int a = 0; a < NW; a++)
      chk($sformatf("ram[%0d]", a), mem[a], (a < limit) ? model_word(a) : init_mem[a]);
  endtask

  task automatic finish_pass();
    wait_chk();
    #1 run = 1'b0;
    @(negedge clk);
    chk("valid_hold", WW'(valid), WW'(1));
    @(posedge clk);
    #1;
    chk("valid_drop", WW'(valid), WW'(0));
    chk("raddr_idle", WW'(raddr), WW'(0));
    chk("we_count", WW'(we_cnt), WW'(NW));
    check_ram(NW);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    x_bus = '0;
    d_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_raddr", WW'(raddr), WW'(0));
    chk("rst_waddr", WW'(waddr), WW'(0));
    chk("rst_wdata", wdata, WW'(0));
    chk("rst_we", WW'(we), WW'(0));
    chk("rst_valid", WW'(valid), WW'(0));
    @(negedge clk);
    rst = 1'b0;

    chk("model_basic", WW'(upd(100, 256, 64)), WW'(84));
    chk("model_floor_neg", WW'(upd(0, 256, -1)), WW'(1));
    chk("model_floor_pos", WW'(upd(0, 256, 1)), WW'(0));
    chk("model_sat_lo", WW'(upd(-32760, 256, 64)), WW'(-32768));
    chk("model_sat_hi", WW'(upd(32760, 256, -64)), WW'(32767));
    chk("model_no_wrap", WW'(upd(32767, -32768, 127)), WW'(32767));

    // Basic update.
    for (int h = 0; h < HD; h++) xv[h] = 256;
    for (int c = 0; c < CN; c++) dv[c] = 64;
    for (int a = 0; a < NW; a++)
      for (int l = 0; l < DN; l++) set_lane(a, l, 100);
    load_ram();
    start_pass(NW + 4);
    finish_pass();
    chk("basic_first", WW'(lane_of(mem[0], 0)), WW'(84));
    chk("basic_last", WW'(lane_of(mem[NW-1], 15)), WW'(84));

    // Floor rounding.
    for (int c = 0; c < CN; c++) dv[c] = (c % 2 == 0) ? -1 : 1;
    for (int a = 0; a < NW; a++) stage_mem[a] = '0;
    load_ram();
    start_pass(NW + 4);
    finish_pass();
    chk("floor_neg", WW'(lane_of(mem[0], 0)), WW'(1));
    chk("floor_pos", WW'(lane_of(mem[0], 1)), WW'(0));

    // Saturation.
    xv[1] = -32768;
    for (int c = 0; c < CN; c++) dv[c] = 0;
    dv[0] = 64;
    dv[1] = -64;
    dv[2] = 127;
    set_lane(0, 0, -32760);
    set_lane(0, 1, 32760);
    set_lane(CH, 2, 32767);
    load_ram();
    start_pass(NW + 4);
    finish_pass();
    chk("sat_lo", WW'(lane_of(mem[0], 0)), WW'(-32768));
    chk("sat_hi", WW'(lane_of(mem[0], 1)), WW'(32767));
    chk("sat_no_wrap", WW'(lane_of(mem[CH], 2)), WW'(32767));

    // Random mapping.
    randomize_all();
    load_ram();
    start_pass(NW + 4);
    finish_pass();

    // Abort after raddr=100, then restart.
    randomize_all();
    load_ram();
    start_pass(100);
    wait_chk();
    #1 run = 1'b0;
    @(negedge clk);
    chk("abort_we", WW'(we), WW'(0));
    chk("abort_valid", WW'(valid), WW'(0));
    @(posedge clk);
    #1;
    chk("abort_raddr", WW'(raddr), WW'(0));
    chk("abort_valid_idle", WW'(valid), WW'(0));
    check_ram(98);
    start_pass(NW + 4);
    finish_pass();

    // Reset mid-pass, then a full pass.
    randomize_all();
    load_ram();
    start_pass(50);
    wait_chk();
    #1 rst = 1'b1;
    #1;
    chk("mrst_we", WW'(we), WW'(0));
    chk("mrst_valid", WW'(valid), WW'(0));
    chk("mrst_waddr", WW'(waddr), WW'(0));
    chk("mrst_wdata", wdata, WW'(0));
    chk("mrst_raddr", WW'(raddr), WW'(0));
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    start_pass(NW + 4);
    finish_pass();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
